// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {sub_addr, data} init table and issues one
// 24-bit I2C write per entry through the GO/END/ACK handshake. It retries
// NACKed entries and also generates the bit-slot strobe and the SCL phase clock.
module i2c_cfg_sequencer #(
  parameter int unsigned CLK_DIV    = 500,
  parameter logic [7:0]  SLAVE_ADDR = 8'h42,
  parameter int unsigned LUT_SIZE   = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned INIT_DELAY = 1000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          start,
  output logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_data,
  output logic          I2C_CLK,
  output logic          I2C_EN,
  output logic [23:0]   I2C_WDATA,
  output logic          WR,
  output logic          GO,
  input  logic          END,
  input  logic          ACK,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_index
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV / 2);
  localparam logic [PW-1:0] DLY_LAST  = PW'((INIT_DELAY > 0) ? INIT_DELAY - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [AW-1:0] ADDR_LAST = AW'(LUT_SIZE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_LATCH, S_GO_WAIT,
    S_RELEASE, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_div_cnt, w_div_nxt;
  logic            r_en, r_sclk;
  logic [PW-1:0]   r_dly_cnt, w_dly_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [AW-1:0]   r_err_idx, w_err_idx_nxt;
  logic [23:0]     r_wdata, w_wdata_nxt;
  logic            r_ack, w_ack_nxt;
  logic            r_go, w_go_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;

  assign w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);

  // Free-running bit-slot divider; strobe and SCL phase registered off the next count
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_div_cnt <= '0;
      r_en      <= 1'b0;
      r_sclk    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_en      <= (w_div_nxt == DIV_LAST);
      r_sclk    <= (w_div_nxt >= DIV_HALF);
    end
  end

  // Sequencer state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (AUTO_START)  w_state_nxt = S_PWR_WAIT;
        else if (start)  w_state_nxt = S_FETCH;
      end
      S_PWR_WAIT: begin
        if (INIT_DELAY == 0 || (r_en && r_dly_cnt == DLY_LAST)) w_state_nxt = S_FETCH;
      end
      S_FETCH:   w_state_nxt = S_LATCH;
      S_LATCH:   w_state_nxt = S_GO_WAIT;
      S_GO_WAIT: if (END)  w_state_nxt = S_RELEASE;
      S_RELEASE: if (!END) w_state_nxt = S_CHECK;
      S_CHECK: begin
        if (!r_ack)                  w_state_nxt = (r_addr == ADDR_LAST) ? S_DONE : S_FETCH;
        else if (r_retry < RETRY_MAX) w_state_nxt = S_LATCH;
        else                         w_state_nxt = S_FAIL;
      end
      S_DONE, S_FAIL: if (start) w_state_nxt = S_FETCH;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values, keyed on the transition being taken
  always_comb begin
    w_addr_nxt    = r_addr;
    w_retry_nxt   = r_retry;
    w_dly_nxt     = r_dly_cnt;
    w_wdata_nxt   = r_wdata;
    w_ack_nxt     = r_ack;
    w_err_idx_nxt = r_err_idx;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (w_state_nxt == S_FETCH) begin
          w_addr_nxt  = '0;
          w_retry_nxt = '0;
        end
      end
      S_PWR_WAIT: begin
        if (w_state_nxt == S_FETCH) begin
          w_addr_nxt  = '0;
          w_retry_nxt = '0;
        end else if (r_en) begin
          w_dly_nxt = r_dly_cnt + PW'(1);
        end
      end
      S_LATCH:   w_wdata_nxt = {SLAVE_ADDR, tbl_data};
      S_GO_WAIT: if (END) w_ack_nxt = ACK;
      S_CHECK: begin
        if (w_state_nxt == S_FETCH) begin
          w_addr_nxt  = r_addr + AW'(1);
          w_retry_nxt = '0;
        end else if (w_state_nxt == S_LATCH) begin
          w_retry_nxt = r_retry + RW'(1);
        end else if (w_state_nxt == S_FAIL) begin
          w_err_idx_nxt = r_addr;
        end
      end
      default: ;
    endcase
    w_go_nxt   = (w_state_nxt == S_GO_WAIT);
    w_busy_nxt = w_state_nxt inside {S_PWR_WAIT, S_FETCH, S_LATCH, S_GO_WAIT, S_RELEASE, S_CHECK};
    w_done_nxt = (w_state_nxt == S_DONE);
    w_err_nxt  = (w_state_nxt == S_FAIL);
  end

  // Datapath and status registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_addr    <= '0;
      r_retry   <= '0;
      r_dly_cnt <= '0;
      r_wdata   <= '0;
      r_ack     <= 1'b0;
      r_err_idx <= '0;
      r_go      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_addr    <= w_addr_nxt;
      r_retry   <= w_retry_nxt;
      r_dly_cnt <= w_dly_nxt;
      r_wdata   <= w_wdata_nxt;
      r_ack     <= w_ack_nxt;
      r_err_idx <= w_err_idx_nxt;
      r_go      <= w_go_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign tbl_addr  = r_addr;
  assign I2C_CLK   = r_sclk;
  assign I2C_EN    = r_en;
  assign I2C_WDATA = r_wdata;
  assign WR        = 1'b1;
  assign GO        = r_go;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_index = r_err_idx;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: table ROM, a simple byte-controller model and
// a transaction-level expectation of which writes appear and how a run ends.
module tb_i2c_cfg_sequencer;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned LUT     = 3;
  localparam int unsigned AW      = 4;
  localparam int unsigned MAXR    = 3;
  localparam int unsigned INIT_D  = 4;
  localparam int unsigned XFER    = 3;

  logic          iCLK   = 1'b0;
  logic          iRST_N = 1'b1;
  logic          start  = 1'b0;
  logic [AW-1:0] tbl_addr, err_index;
  logic [15:0]   tbl_data;
  logic          I2C_CLK, I2C_EN, WR, GO, busy, done, err;
  logic [23:0]   I2C_WDATA;
  logic          END = 1'b0;
  logic          ACK = 1'b0;

  i2c_cfg_sequencer #(
    .CLK_DIV(CLK_DIV), .SLAVE_ADDR(8'h42), .LUT_SIZE(LUT), .AW(AW),
    .MAX_RETRY(MAXR), .INIT_DELAY(INIT_D), .AUTO_START(1'b1)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .start(start), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .I2C_CLK(I2C_CLK), .I2C_EN(I2C_EN),
    .I2C_WDATA(I2C_WDATA), .WR(WR), .GO(GO), .END(END), .ACK(ACK),
    .busy(busy), .done(done), .err(err), .err_index(err_index)
  );

  always #5 iCLK = ~iCLK;

  logic [15:0] tbl [0:15];
  int          nack [0:15];

  // Synchronous table ROM: data valid one clock after the address
  always @(posedge iCLK) tbl_data <= tbl[tbl_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] exp_wd [$];
  bit          exp_ack [$];
  int          n_go;
  bit          exp_done, exp_err;
  int          exp_idx;

  // Expected write list: each entry retried while NACKed, up to MAXR re-issues
  task automatic plan_run();
    exp_wd.delete();
    exp_ack.delete();
    n_go = 0; exp_done = 1'b1; exp_err = 1'b0; exp_idx = 0;
    for (int i = 0; i < LUT; i++) begin
      for (int a = 0; a <= MAXR; a++) begin
        exp_wd.push_back({8'h42, tbl[i]});
        exp_ack.push_back(a < nack[i]);
        if (a >= nack[i]) break;
        if (a == MAXR) begin exp_err = 1'b1; exp_done = 1'b0; exp_idx = i; end
      end
      if (exp_err) break;
    end
  endtask

  bit          act, chk_fall, prev_go, cur_ack;
  int          slot;
  logic [23:0] prev_wd;

  // Byte-controller model plus handshake monitor, evaluated 1 time unit after each edge
  always @(posedge iCLK) begin
    #1;
    if (!iRST_N) begin
      END = 1'b0; ACK = 1'b0; act = 1'b0; chk_fall = 1'b0; prev_go = 1'b0;
    end else begin
      if (chk_fall) begin
        chk("go_fall_after_end", GO, 1'b0);
        chk_fall = 1'b0;
      end
      if (GO && !prev_go) begin
        chk("go_rise_end_low", END, 1'b0);
        chk("go_addr_range", tbl_addr < LUT, 1'b1);
        chk("go_in_plan", n_go < exp_wd.size(), 1'b1);
        if (n_go < exp_wd.size()) begin
          chk($sformatf("wdata_%0d", n_go), I2C_WDATA, exp_wd[n_go]);
          cur_ack = exp_ack[n_go];
        end else begin
          cur_ack = 1'b0;
        end
        n_go++;
      end else if (GO && prev_go) begin
        chk("wdata_stable", I2C_WDATA, prev_wd);
      end
      if (END) begin
        if (!GO && I2C_EN) END = 1'b0;
      end else if (act) begin
        if (I2C_EN) begin
          slot++;
          if (slot == XFER) begin
            END = 1'b1; ACK = cur_ack; act = 1'b0; chk_fall = 1'b1;
          end
        end
      end else if (GO) begin
        act = 1'b1; slot = 0;
      end
      prev_go = GO;
      prev_wd = I2C_WDATA;
    end
  end

  task automatic pulse_start();
    @(negedge iCLK) start = 1'b1;
    @(negedge iCLK) start = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    bit hit = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge iCLK);
      if (done || err) begin hit = 1'b1; break; end
    end
    chk({tag, "_finish"}, hit, 1'b1);
  endtask

  task automatic check_end(input string tag);
    repeat (40) @(negedge iCLK);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_go_count"}, n_go, exp_wd.size());
    if (exp_err) chk({tag, "_err_index"}, err_index, exp_idx);
    if (exp_done) chk({tag, "_last_addr"}, tbl_addr, LUT - 1);
  endtask

  task automatic new_table();
    for (int i = 0; i < 16; i++) tbl[i] = 16'($urandom);
  endtask

  initial begin
    bit seen;
    int cyc;
    new_table();
    for (int i = 0; i < 16; i++) nack[i] = 0;
    plan_run();

    // Reset values
    #2 iRST_N = 1'b0;
    #1;
    chk("rst_go", GO, 1'b0);
    chk("rst_en", I2C_EN, 1'b0);
    chk("rst_sclk", I2C_CLK, 1'b0);
    chk("rst_wdata", I2C_WDATA, 24'h0);
    chk("rst_addr", tbl_addr, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_err_index", err_index, 0);
    chk("wr_const", WR, 1'b1);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;

    // Divider: strobe on the last count, SCL high for the upper half
    for (int n = 1; n <= 3 * CLK_DIV; n++) begin
      @(negedge iCLK);
      chk($sformatf("en_%0d", n), I2C_EN, (n % CLK_DIV) == CLK_DIV - 1);
      chk($sformatf("sclk_%0d", n), I2C_CLK, (n % CLK_DIV) >= CLK_DIV / 2);
    end
    wait_fin("auto");
    check_end("auto");

    // Entry 1 NACKed once
    new_table();
    nack[1] = 1;
    plan_run();
    pulse_start();
    chk("restart_done_clr", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_fin("nack1");
    check_end("nack1");

    // Entry 2 always NACKed, start while busy ignored
    new_table();
    nack[1] = 0; nack[2] = 99;
    plan_run();
    pulse_start();
    repeat (25) @(negedge iCLK);
    pulse_start();
    wait_fin("fail2");
    check_end("fail2");

    // Start after FAIL reruns from entry 0
    new_table();
    nack[2] = 0;
    plan_run();
    pulse_start();
    chk("refail_err_clr", err, 1'b0);
    chk("refail_addr0", tbl_addr, 0);
    chk("refail_busy", busy, 1'b1);
    wait_fin("rerun");
    check_end("rerun");

    // Async reset while entry 1 is in GO_WAIT
    new_table();
    plan_run();
    pulse_start();
    seen = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge iCLK);
      if (n_go == 2 && GO) begin seen = 1'b1; break; end
    end
    chk("mid_go_seen", seen, 1'b1);
    #2 iRST_N = 1'b0;
    #1;
    chk("mid_rst_go", GO, 1'b0);
    chk("mid_rst_wdata", I2C_WDATA, 24'h0);
    chk("mid_rst_addr", tbl_addr, 0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_en", I2C_EN, 1'b0);
    repeat (2) @(negedge iCLK);
    plan_run();
    @(negedge iCLK) iRST_N = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge iCLK);
      if (GO) begin cyc = c; break; end
    end
    chk("init_delay_lo", cyc >= INIT_D * CLK_DIV, 1'b1);
    chk("init_delay_hi", cyc <= (INIT_D + 1) * CLK_DIV, 1'b1);
    wait_fin("post_rst");
    check_end("post_rst");

    // Random NACK patterns
    for (int r = 0; r < 3; r++) begin
      new_table();
      for (int i = 0; i < LUT; i++) nack[i] = $urandom_range(0, 4);
      plan_run();
      pulse_start();
      wait_fin($sformatf("rnd%0d", r));
      check_end($sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
